// File: rtl/sram_banked_mc_if.sv
// Request/response bus of the banked scratchpad.
//   master : requester side (drives req_*, data, rsp_ready)
//   slave  : memory side (drives req_ready, rsp_valid, rsp_data, conflict_cnt)
// Lane i occupies [W*(i+1)-1 -: W] of the packed addr/data/rsp_data vectors.
interface sram_banked_mc_if #(
   parameter int DATA_WIDTH         = 8,
   parameter int ADDRW              = 12,
   parameter int MAX_CHANNELS       = 16,
   parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1),
   parameter int CNT_WIDTH          = 32
);
   logic                               req_valid;
   logic                               req_ready;
   logic                               req_we;
   logic [NUM_CHANNELS_WIDTH-1:0]      num_channels;
   logic [ADDRW*MAX_CHANNELS-1:0]      addr;
   logic [DATA_WIDTH*MAX_CHANNELS-1:0] data;
   logic                               rsp_valid;
   logic                               rsp_ready;
   logic [DATA_WIDTH*MAX_CHANNELS-1:0] rsp_data;
   logic [CNT_WIDTH-1:0]               conflict_cnt;

   modport master (
      output req_valid, req_we, num_channels, addr, data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, conflict_cnt
   );

   modport slave (
      input  req_valid, req_we, num_channels, addr, data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, conflict_cnt
   );
endinterface

// File: rtl/sram_banked_mc.sv
// Word-interleaved multi-bank scratchpad serving one vector request at a time.
// Each round every bank serves its lowest pending lane; same-address reads coalesce.
// Ports: clk_i (rising edge), rst_n_i (async, active low), bus (slave modport of
// sram_banked_mc_if: request handshake, response handshake, conflict counter).
//
//  state | meaning
//  IDLE  | ready for a request
//  SERVE | one bank round per cycle until no lane is pending
//  DRAIN | merge the read data of the final round
//  RESP  | response held until rsp_ready
module sram_banked_mc #(
   parameter int DATA_WIDTH         = 8,
   parameter int N_ENTRIES          = 4096,
   parameter int ADDRW              = $clog2(N_ENTRIES),
   parameter int MAX_CHANNELS       = 16,
   parameter int NUM_CHANNELS_WIDTH = $clog2(MAX_CHANNELS + 1),
   parameter int NUM_BANKS          = 4,
   parameter int BANKW              = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   parameter int CNT_WIDTH          = 32
) (
   input logic            clk_i,
   input logic            rst_n_i,
   sram_banked_mc_if.slave bus
);
   localparam int ROWS  = N_ENTRIES / NUM_BANKS;
   localparam int ROWW  = ADDRW - BANKW;
   localparam int LANEW = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;

   typedef enum logic [1:0] {IDLE, SERVE, DRAIN, RESP} state_t;
   state_t state_q, state_d;

   logic [DATA_WIDTH-1:0]         mem [NUM_BANKS][ROWS];
   logic [DATA_WIDTH-1:0]         rd_data_q [NUM_BANKS];

   logic                          we_q;
   logic [ADDRW-1:0]              addr_q [MAX_CHANNELS];
   logic [DATA_WIDTH-1:0]         data_q [MAX_CHANNELS];
   logic [MAX_CHANNELS-1:0]       pending_q;
   logic [MAX_CHANNELS-1:0]       rd_lane_q;
   logic [DATA_WIDTH*MAX_CHANNELS-1:0] rsp_data_q;
   logic [CNT_WIDTH-1:0]          cnt_q;
   logic [NUM_CHANNELS_WIDTH-1:0] rnd_q;

   logic [BANKW-1:0]              lane_bank [MAX_CHANNELS];
   logic [NUM_BANKS-1:0]          gnt_vld;
   logic [LANEW-1:0]              gnt_lane [NUM_BANKS];
   logic [ROWW-1:0]               gnt_row [NUM_BANKS];
   logic [DATA_WIDTH-1:0]         gnt_wdata [NUM_BANKS];
   logic [MAX_CHANNELS-1:0]       grant;
   logic [NUM_CHANNELS_WIDTH-1:0] nch;
   logic [MAX_CHANNELS-1:0]       lane_mask;
   logic [CNT_WIDTH:0]            cnt_sum;

   always_comb begin
      nch = (bus.num_channels > NUM_CHANNELS_WIDTH'(MAX_CHANNELS)) ?
            NUM_CHANNELS_WIDTH'(MAX_CHANNELS) : bus.num_channels;
      for (int i = 0; i < MAX_CHANNELS; i++)
         lane_mask[i] = NUM_CHANNELS_WIDTH'(i) < nch;
   end

   // Descending scan so the lowest pending lane of each bank is the one left standing.
   always_comb begin
      for (int i = 0; i < MAX_CHANNELS; i++)
         lane_bank[i] = addr_q[i][BANKW-1:0];
      for (int b = 0; b < NUM_BANKS; b++) begin
         gnt_vld[b]  = 1'b0;
         gnt_lane[b] = '0;
      end
      for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            gnt_vld[lane_bank[i]]  = 1'b1;
            gnt_lane[lane_bank[i]] = LANEW'(i);
         end
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         gnt_row[b]   = addr_q[gnt_lane[b]][ADDRW-1:BANKW];
         gnt_wdata[b] = data_q[gnt_lane[b]];
      end
      // Reads ride along with any granted lane of identical address; writes never do.
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         grant[i] = 1'b0;
         if (pending_q[i]) begin
            if (we_q) grant[i] = gnt_lane[lane_bank[i]] == LANEW'(i);
            else      grant[i] = addr_q[i] == addr_q[gnt_lane[lane_bank[i]]];
         end
      end
   end

   // rnd_q holds the rounds already finished, i.e. K-1 in the final round.
   always_comb begin
      cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(rnd_q);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.req_valid) state_d = SERVE;
         SERVE: if ((pending_q & ~grant) == '0) state_d = DRAIN;
         DRAIN: state_d = RESP;
         RESP:  if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready    = state_q == IDLE;
      bus.rsp_valid    = state_q == RESP;
      bus.rsp_data     = rsp_data_q;
      bus.conflict_cnt = cnt_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         we_q       <= 1'b0;
         pending_q  <= '0;
         rd_lane_q  <= '0;
         rsp_data_q <= '0;
         cnt_q      <= '0;
         rnd_q      <= '0;
         for (int i = 0; i < MAX_CHANNELS; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MAX_CHANNELS; i++)
            if (rd_lane_q[i])
               rsp_data_q[DATA_WIDTH*i +: DATA_WIDTH] <= rd_data_q[lane_bank[i]];
         case (state_q)
            IDLE: begin
               rd_lane_q <= '0;
               rnd_q     <= '0;
               if (bus.req_valid) begin
                  we_q      <= bus.req_we;
                  pending_q <= lane_mask;
                  for (int i = 0; i < MAX_CHANNELS; i++) begin
                     addr_q[i] <= bus.addr[ADDRW*i +: ADDRW];
                     data_q[i] <= bus.data[DATA_WIDTH*i +: DATA_WIDTH];
                  end
               end
            end
            SERVE: begin
               pending_q <= pending_q & ~grant;
               rd_lane_q <= we_q ? '0 : grant;
               rnd_q     <= rnd_q + 1'b1;
               if (state_d == DRAIN)
                  cnt_q <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
            end
            DRAIN: rd_lane_q <= '0;
            RESP:  if (bus.rsp_ready) rsp_data_q <= '0;
            default: ;
         endcase
      end
   end

   // RAM array carries no reset; contents survive an aborted request.
   always_ff @(posedge clk_i) begin
      if (state_q == SERVE) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt_vld[b]) begin
               if (we_q) mem[b][gnt_row[b]] <= gnt_wdata[b];
               else      rd_data_q[b]       <= mem[b][gnt_row[b]];
            end
         end
      end
   end
endmodule

// File: tb/tb_sram_banked_mc.sv
module tb_sram_banked_mc;
   localparam int DW  = 8;
   localparam int AW  = 12;
   localparam int MC  = 4;
   localparam int NCW = 3;
   localparam int CW  = 32;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   sram_banked_mc_if #(.DATA_WIDTH(DW), .ADDRW(AW), .MAX_CHANNELS(MC),
                       .NUM_CHANNELS_WIDTH(NCW), .CNT_WIDTH(CW)) bus ();

   sram_banked_mc #(.DATA_WIDTH(DW), .N_ENTRIES(4096), .ADDRW(AW), .MAX_CHANNELS(MC),
                    .NUM_CHANNELS_WIDTH(NCW), .NUM_BANKS(4), .BANKW(2), .CNT_WIDTH(CW))
      dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [4*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
      pa = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endfunction

   // Issue one request, wait for the response, optionally hold it off, then consume it.
   task automatic xact(input string tag, input logic we, input logic [NCW-1:0] nch,
                       input logic [4*AW-1:0] a, input logic [31:0] d,
                       input int exp_lat, input logic [31:0] exp_data,
                       input logic [31:0] exp_cnt, input int hold);
      int lat;
      logic [31:0] snap;
      @(negedge clk_i);
      chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.num_channels = nch;
      bus.addr         = a;
      bus.data         = d;
      @(posedge clk_i); #1;
      bus.req_valid = 1'b0;
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
      end
      if (lat >= 40) chk({tag, "_rsp_timeout"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_data"}, 64'(bus.rsp_data), 64'(exp_data));
      chk({tag, "_conflict_cnt"}, 64'(bus.conflict_cnt), 64'(exp_cnt));
      snap = bus.rsp_data;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk_i); #1;
         chk({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
         chk({tag, "_hold_data"}, 64'(bus.rsp_data), 64'(snap));
         chk({tag, "_hold_req_ready"}, 64'(bus.req_ready), 64'd0);
      end
      @(negedge clk_i);
      bus.rsp_ready = 1'b1;
      @(posedge clk_i); #1;
      bus.rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, "_rsp_clear"}, 64'(bus.rsp_data), 64'd0);
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.num_channels = '0;
      bus.addr         = '0;
      bus.data         = '0;
      bus.rsp_ready    = 1'b0;
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;

      // conflict-free write then read of 0..3
      xact("wr0123", 1'b1, 3'd4, pa(0, 1, 2, 3), 32'hDDCCBBAA, 2, 32'h0, 32'd0, 0);
      xact("rd0123", 1'b0, 3'd4, pa(0, 1, 2, 3), 32'h0, 2, 32'hDDCCBBAA, 32'd0, 0);
      // bank-0 pile-up: write 4,8,12 (K=3), read 0,4,8,12 (K=4)
      xact("wr_b0", 1'b1, 3'd3, pa(4, 8, 12, 16), 32'h77C08844, 4, 32'h0, 32'd2, 0);
      xact("rd_b0", 1'b0, 3'd4, pa(0, 4, 8, 12), 32'h0, 5, 32'hC08844AA, 32'd5, 0);
      // coalesced read of addr 5
      xact("wr5", 1'b1, 3'd1, pa(5, 0, 0, 0), 32'h00000055, 2, 32'h0, 32'd5, 0);
      xact("rd5x4", 1'b0, 3'd4, pa(5, 5, 5, 5), 32'h0, 2, 32'h55555555, 32'd5, 0);
      // duplicate-address write: lane2 overrides lane0, lane3 inactive
      xact("wr_dup", 1'b1, 3'd3, pa(7, 8, 7, 5), 32'h99223311, 3, 32'h0, 32'd6, 0);
      xact("rd_dup", 1'b0, 3'd2, pa(7, 8, 5, 5), 32'h0, 2, 32'h00003322, 32'd6, 0);
      xact("rd5_kept", 1'b0, 3'd1, pa(5, 0, 0, 0), 32'h0, 2, 32'h00000055, 32'd6, 0);
      // backpressure with clamped lane count, then empty request
      xact("rd_clamp", 1'b0, 3'd7, pa(0, 1, 2, 3), 32'h0, 2, 32'hDDCCBBAA, 32'd6, 3);
      xact("rd_empty", 1'b0, 3'd0, pa(0, 1, 2, 3), 32'h0, 2, 32'h0, 32'd6, 0);

      // reset during SERVE
      @(negedge clk_i);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.num_channels = 3'd4;
      bus.addr         = pa(0, 4, 8, 12);
      @(posedge clk_i); #1;
      bus.req_valid = 1'b0;
      @(posedge clk_i); #1;
      chk("midrst_busy", 64'(bus.req_ready), 64'd0);
      rst_n_i = 1'b0;
      #1;
      chk("midrst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("midrst_rsp_data", 64'(bus.rsp_data), 64'd0);
      chk("midrst_cnt", 64'(bus.conflict_cnt), 64'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      xact("post_rst", 1'b0, 3'd2, pa(5, 7, 0, 0), 32'h0, 2, 32'h00002255, 32'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
